// File: rtl/down_counter_timer_pkg.sv
// Shared definitions for the down_counter_timer block: default geometry
// and the controller state encoding.
package down_counter_timer_pkg;

    localparam int unsigned DCT_WIDTH     = 5;
    localparam int unsigned DCT_MAX_VALUE = 25;

    // Encoding 2'd3 is unreachable; the controller treats it as IDLE.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } dct_state_e;

endpackage

// File: rtl/down_counter_timer.sv
// Loadable down-counter/timer: counts from a programmed reload value down
// to zero. One-shot or auto-reload, with a registered terminal-count
// pulse and busy/done status decoded from the controller state.
module down_counter_timer
    import down_counter_timer_pkg::*;
#(
    parameter int unsigned      WIDTH     = DCT_WIDTH,
    parameter logic [WIDTH-1:0] MAX_VALUE = WIDTH'(DCT_MAX_VALUE)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             start,
    input  logic             stop,
    input  logic             en,
    input  logic             auto_reload,
    output logic [WIDTH-1:0] q,
    output logic             tc,
    output logic             busy,
    output logic             done
);

    dct_state_e       state;
    dct_state_e       state_next;
    dct_state_e       start_state;
    logic [WIDTH-1:0] reload_reg;
    logic [WIDTH-1:0] q_next;
    logic             tc_next;
    logic             reload_zero;

    function automatic logic [WIDTH-1:0] clamp(input logic [WIDTH-1:0] v);
        return (v > MAX_VALUE) ? MAX_VALUE : v;
    endfunction

    // Controller state register.
    always_ff @(posedge clk) begin : state_reg
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state, next count and terminal-count pulse; stop > start > en.
    always_comb begin : next_state_logic
        // A start from a zero reload value terminates on the same edge.
        reload_zero = (reload_reg == '0);
        start_state = (reload_zero && !auto_reload) ? ST_DONE : ST_RUN;
        state_next  = state;
        q_next      = q;
        tc_next     = 1'b0;
        if (stop) begin
            state_next = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        q_next     = reload_reg;
                        tc_next    = reload_zero;
                        state_next = start_state;
                    end
                end
                ST_RUN: begin
                    if (start) begin
                        q_next     = reload_reg;
                        tc_next    = reload_zero;
                        state_next = start_state;
                    end else if (en) begin
                        if (q > WIDTH'(1)) begin
                            q_next = q - WIDTH'(1);
                        end else if (q == WIDTH'(1)) begin
                            q_next  = '0;
                            tc_next = 1'b1;
                            if (!auto_reload) begin
                                state_next = ST_DONE;
                            end
                        end else if (auto_reload) begin
                            q_next  = reload_reg;
                            tc_next = reload_zero;
                        end else begin
                            state_next = ST_DONE;
                        end
                    end
                end
                default: begin
                    state_next = ST_IDLE;
                end
            endcase
        end
    end

    // Count and terminal-count registers.
    always_ff @(posedge clk) begin : datapath_reg
        if (rst) begin
            q  <= '0;
            tc <= 1'b0;
        end else begin
            q  <= q_next;
            tc <= tc_next;
        end
    end

    // Reload register; a same-cycle start still sees the previous value.
    always_ff @(posedge clk) begin : reload_reg_p
        if (rst) begin
            reload_reg <= MAX_VALUE;
        end else if (load) begin
            reload_reg <= clamp(load_val);
        end
    end

    // Status outputs decoded directly from the state register.
    always_comb begin : output_logic
        busy = (state == ST_RUN);
        done = (state == ST_DONE);
    end

endmodule

// File: tb/tb_down_counter_timer.sv
// Self-checking bench for down_counter_timer: directed scenarios with
// explicit expectations, then randomized stimulus against a reference model.
module tb_down_counter_timer;

    localparam int MAXV = 25;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       load = 1'b0;
    logic [4:0] load_val = '0;
    logic       start = 1'b0;
    logic       stop = 1'b0;
    logic       en = 1'b0;
    logic       auto_reload = 1'b0;
    logic [4:0] q;
    logic       tc;
    logic       busy;
    logic       done;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: mode 0 idle, 1 counting, 2 finished.
    int m_q = 0;
    int m_reload = MAXV;
    int m_mode = 0;
    bit m_tc = 1'b0;

    down_counter_timer #(.WIDTH(5), .MAX_VALUE(5'd25)) dut (
        .clk(clk), .rst(rst), .load(load), .load_val(load_val),
        .start(start), .stop(stop), .en(en), .auto_reload(auto_reload),
        .q(q), .tc(tc), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    task automatic model_step();
        int new_reload;
        new_reload = m_reload;
        m_tc = 1'b0;
        if (rst) begin
            m_q = 0; m_mode = 0; m_reload = MAXV;
            return;
        end
        if (load) new_reload = (int'(load_val) > MAXV) ? MAXV : int'(load_val);
        if (stop) begin
            m_mode = 0;
        end else if (start) begin
            m_q = m_reload;
            m_mode = 1;
            if (m_reload == 0) begin
                m_tc = 1'b1;
                if (!auto_reload) m_mode = 2;
            end
        end else if (m_mode == 1 && en) begin
            if (m_q == 0) begin
                if (auto_reload) begin
                    m_q = m_reload;
                    m_tc = (m_reload == 0);
                end else begin
                    m_mode = 2;
                end
            end else begin
                m_q = m_q - 1;
                if (m_q == 0) begin
                    m_tc = 1'b1;
                    if (!auto_reload) m_mode = 2;
                end
            end
        end
        m_reload = new_reload;
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic test_reset();
        logic [7:0] exp, obs;
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        exp = 8'h00;
        obs = {q, tc, busy, done};
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL reset: q=%0d tc=%b busy=%b done=%b, expected q=%0d tc=%b busy=%b done=%b",
                     obs[7:3], obs[2], obs[1], obs[0], exp[7:3], exp[2], exp[1], exp[0]);
        end
    endtask

    task automatic test_oneshot();
        logic [7:0] exp, obs;
        auto_reload = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        exp = {5'd25, 1'b0, 1'b1, 1'b0};
        obs = {q, tc, busy, done};
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL oneshot_start: q=%0d tc=%b busy=%b done=%b, expected q=%0d tc=%b busy=%b done=%b",
                     obs[7:3], obs[2], obs[1], obs[0], exp[7:3], exp[2], exp[1], exp[0]);
        end
        en = 1'b1;
        for (int i = 1; i <= 28; i++) begin
            tick();
            if (i <= 25) exp = {5'(25 - i), 1'(i == 25), 1'(i != 25), 1'(i == 25)};
            else         exp = {5'd0, 1'b0, 1'b0, 1'b1};
            obs = {q, tc, busy, done};
            n_checks++;
            if (obs !== exp) begin
                n_fail++;
                $display("FAIL oneshot_count[%0d]: q=%0d tc=%b busy=%b done=%b, expected q=%0d tc=%b busy=%b done=%b",
                         i, obs[7:3], obs[2], obs[1], obs[0], exp[7:3], exp[2], exp[1], exp[0]);
            end
        end
        en = 1'b0;
    endtask

    task automatic test_auto_reload();
        logic [7:0] exp, obs;
        auto_reload = 1'b1;
        load = 1'b1;
        load_val = 5'd3;
        tick();
        load = 1'b0;
        exp = {5'd0, 1'b0, 1'b0, 1'b1};
        obs = {q, tc, busy, done};
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL load_keeps_state: q=%0d tc=%b busy=%b done=%b, expected q=%0d tc=%b busy=%b done=%b",
                     obs[7:3], obs[2], obs[1], obs[0], exp[7:3], exp[2], exp[1], exp[0]);
        end
        start = 1'b1;
        tick();
        start = 1'b0;
        en = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            tick();
            exp = {5'(3 - (i % 4)), 1'((i % 4) == 3), 1'b1, 1'b0};
            obs = {q, tc, busy, done};
            n_checks++;
            if (obs !== exp) begin
                n_fail++;
                $display("FAIL auto_reload[%0d]: q=%0d tc=%b busy=%b done=%b, expected q=%0d tc=%b busy=%b done=%b",
                         i, obs[7:3], obs[2], obs[1], obs[0], exp[7:3], exp[2], exp[1], exp[0]);
            end
        end
        en = 1'b0;
        stop = 1'b1;
        tick();
        stop = 1'b0;
        auto_reload = 1'b0;
        exp = {5'd3, 1'b0, 1'b0, 1'b0};
        obs = {q, tc, busy, done};
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL auto_stop: q=%0d tc=%b busy=%b done=%b, expected q=%0d tc=%b busy=%b done=%b",
                     obs[7:3], obs[2], obs[1], obs[0], exp[7:3], exp[2], exp[1], exp[0]);
        end
    endtask

    task automatic test_clamp();
        logic [7:0] exp, obs;
        load = 1'b1;
        load_val = 5'd31;
        tick();
        load = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        exp = {5'd25, 1'b0, 1'b1, 1'b0};
        obs = {q, tc, busy, done};
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL clamp: q=%0d tc=%b busy=%b done=%b, expected q=%0d tc=%b busy=%b done=%b",
                     obs[7:3], obs[2], obs[1], obs[0], exp[7:3], exp[2], exp[1], exp[0]);
        end
        stop = 1'b1;
        tick();
        stop = 1'b0;
    endtask

    task automatic test_en_toggle();
        logic [7:0] exp, obs;
        int k;
        load = 1'b1;
        load_val = 5'd4;
        tick();
        load = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 8; i++) begin
            en = ((i % 2) == 0);
            tick();
            k = i / 2 + 1;
            exp = {5'(4 - k), 1'(en && k == 4), 1'(k < 4), 1'(k == 4)};
            obs = {q, tc, busy, done};
            n_checks++;
            if (obs !== exp) begin
                n_fail++;
                $display("FAIL en_toggle[%0d]: q=%0d tc=%b busy=%b done=%b, expected q=%0d tc=%b busy=%b done=%b",
                         i, obs[7:3], obs[2], obs[1], obs[0], exp[7:3], exp[2], exp[1], exp[0]);
            end
        end
        en = 1'b0;
    endtask

    task automatic test_stop_rst();
        logic [7:0] exp, obs;
        load = 1'b1;
        load_val = 5'd20;
        tick();
        load = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        en = 1'b1;
        repeat (10) tick();
        en = 1'b0;
        stop = 1'b1;
        tick();
        stop = 1'b0;
        exp = {5'd10, 1'b0, 1'b0, 1'b0};
        obs = {q, tc, busy, done};
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL stop_mid: q=%0d tc=%b busy=%b done=%b, expected q=%0d tc=%b busy=%b done=%b",
                     obs[7:3], obs[2], obs[1], obs[0], exp[7:3], exp[2], exp[1], exp[0]);
        end
        en = 1'b1;
        tick();
        en = 1'b0;
        obs = {q, tc, busy, done};
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL idle_ignores_en: q=%0d tc=%b busy=%b done=%b, expected q=%0d tc=%b busy=%b done=%b",
                     obs[7:3], obs[2], obs[1], obs[0], exp[7:3], exp[2], exp[1], exp[0]);
        end
        start = 1'b1;
        tick();
        start = 1'b0;
        en = 1'b1;
        repeat (13) tick();
        exp = {5'd7, 1'b0, 1'b1, 1'b0};
        obs = {q, tc, busy, done};
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL count_to_7: q=%0d tc=%b busy=%b done=%b, expected q=%0d tc=%b busy=%b done=%b",
                     obs[7:3], obs[2], obs[1], obs[0], exp[7:3], exp[2], exp[1], exp[0]);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        en = 1'b0;
        exp = 8'h00;
        obs = {q, tc, busy, done};
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL rst_mid: q=%0d tc=%b busy=%b done=%b, expected q=%0d tc=%b busy=%b done=%b",
                     obs[7:3], obs[2], obs[1], obs[0], exp[7:3], exp[2], exp[1], exp[0]);
        end
        start = 1'b1;
        tick();
        start = 1'b0;
        exp = {5'd25, 1'b0, 1'b1, 1'b0};
        obs = {q, tc, busy, done};
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL rst_reload: q=%0d tc=%b busy=%b done=%b, expected q=%0d tc=%b busy=%b done=%b",
                     obs[7:3], obs[2], obs[1], obs[0], exp[7:3], exp[2], exp[1], exp[0]);
        end
        stop = 1'b1;
        tick();
        stop = 1'b0;
    endtask

    task automatic test_edge_cases();
        logic [7:0] exp[8];
        logic [7:0] obs;
        // Sequence: load 0; start; idle tick; load 9; load 5+start; en;
        // start+en; load 0 while running.
        exp[0] = {5'd25, 1'b0, 1'b0, 1'b0};
        exp[1] = {5'd0,  1'b1, 1'b0, 1'b1};
        exp[2] = {5'd0,  1'b0, 1'b0, 1'b1};
        exp[3] = {5'd0,  1'b0, 1'b0, 1'b1};
        exp[4] = {5'd9,  1'b0, 1'b1, 1'b0};
        exp[5] = {5'd8,  1'b0, 1'b1, 1'b0};
        exp[6] = {5'd5,  1'b0, 1'b1, 1'b0};
        exp[7] = {5'd5,  1'b0, 1'b1, 1'b0};
        auto_reload = 1'b0;
        for (int i = 0; i < 8; i++) begin
            load     = (i == 0) || (i == 3) || (i == 4) || (i == 7);
            load_val = (i == 3) ? 5'd9 : ((i == 4) ? 5'd5 : 5'd0);
            start    = (i == 1) || (i == 4) || (i == 6);
            en       = (i == 5) || (i == 6);
            tick();
            obs = {q, tc, busy, done};
            n_checks++;
            if (obs !== exp[i]) begin
                n_fail++;
                $display("FAIL edge[%0d]: q=%0d tc=%b busy=%b done=%b, expected q=%0d tc=%b busy=%b done=%b",
                         i, obs[7:3], obs[2], obs[1], obs[0], exp[i][7:3], exp[i][2], exp[i][1], exp[i][0]);
            end
        end
        load = 1'b0;
        // Zero reload in auto-reload mode: tc on every enabled cycle.
        auto_reload = 1'b1;
        en = 1'b1;
        start = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            start = 1'b0;
            obs = {q, tc, busy, done};
            n_checks++;
            if (obs !== {5'd0, 1'b1, 1'b1, 1'b0}) begin
                n_fail++;
                $display("FAIL zero_auto[%0d]: q=%0d tc=%b busy=%b done=%b, expected q=0 tc=1 busy=1 done=0",
                         i, obs[7:3], obs[2], obs[1], obs[0]);
            end
        end
        en = 1'b0;
        stop = 1'b1;
        tick();
        stop = 1'b0;
        auto_reload = 1'b0;
        obs = {q, tc, busy, done};
        n_checks++;
        if (obs !== 8'h00) begin
            n_fail++;
            $display("FAIL stop_clears_tc: q=%0d tc=%b busy=%b done=%b, expected q=0 tc=0 busy=0 done=0",
                     obs[7:3], obs[2], obs[1], obs[0]);
        end
    endtask

    task automatic test_random();
        logic [7:0] exp, obs;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            rst   = ($urandom_range(0, 199) == 0);
            stop  = ($urandom_range(0, 29) == 0);
            load  = ($urandom_range(0, 9) == 0);
            start = ($urandom_range(0, 14) == 0);
            en    = ($urandom_range(0, 9) < 6);
            if ($urandom_range(0, 49) == 0) auto_reload = ~auto_reload;
            if ($urandom_range(0, 3) == 0) load_val = 5'($urandom_range(0, 2));
            else                           load_val = 5'($urandom_range(0, 31));
            tick();
            exp = {5'(m_q), m_tc, 1'(m_mode == 1), 1'(m_mode == 2)};
            obs = {q, tc, busy, done};
            n_checks++;
            if (obs !== exp) begin
                n_fail++;
                $display("FAIL random[%0d]: q=%0d tc=%b busy=%b done=%b, expected q=%0d tc=%b busy=%b done=%b",
                         i, obs[7:3], obs[2], obs[1], obs[0], exp[7:3], exp[2], exp[1], exp[0]);
            end
            n_checks++;
            if (!(q <= 5'd25)) begin
                n_fail++;
                $display("FAIL q_bound[%0d]: q=%0d, expected q<=25", i, q);
            end
        end
        rst = 1'b0; stop = 1'b0; load = 1'b0; start = 1'b0; en = 1'b0;
    endtask

    initial begin
        test_reset();
        test_oneshot();
        test_auto_reload();
        test_clamp();
        test_en_toggle();
        test_stop_rst();
        test_edge_cases();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
